// File: rtl/spi_master_ctrl.sv
// Round-robin SPI master: arbitrates NUM_REQ requesters onto one SPI bus,
// one slave select per requester, mode-0 style framing with a select timeout.
module spi_master_ctrl #(
    parameter int REG_WIDTH   = 32,
    parameter int NUM_REQ     = 4,
    parameter int CLK_DIV     = 4,
    parameter int SEL_TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*REG_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]           gnt,
    output logic                         rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [REG_WIDTH-1:0]         rsp_data,
    output logic                         rsp_err,
    output logic [NUM_REQ-1:0]           ss_n,
    output logic                         s_clk,
    output logic                         MOSI,
    input  logic                         MISO,
    output logic                         load,
    output logic                         busy,
    input  logic                         ready
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int BC_W = $clog2(REG_WIDTH) + 1;
    localparam int DV_W = $clog2(CLK_DIV + 1);
    localparam int ST_W = $clog2(SEL_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        LOAD,
        SHIFT,
        DONE,
        GAP
    } state_t;

    state_t               state_q, state_d;
    logic [REG_WIDTH-1:0] sr_q, sr_d;
    logic [ID_W-1:0]      g_q, g_d;
    logic [ID_W-1:0]      last_q, last_d;
    logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [ST_W-1:0]      sel_cnt_q, sel_cnt_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   ss_n_q, ss_n_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic [REG_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 load_q, load_d;
    logic                 busy_q, busy_d;

    logic                 found;
    logic [ID_W-1:0]      pick;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[ID_W'((int'(last_q) + 1 + k) % NUM_REQ)]) begin
                found = 1'b1;
                pick  = ID_W'((int'(last_q) + 1 + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        g_d         = g_q;
        last_d      = last_q;
        bit_cnt_d   = bit_cnt_q;
        div_cnt_d   = div_cnt_q;
        sel_cnt_d   = sel_cnt_q;
        gnt_d       = '0;
        ss_n_d      = ss_n_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = 1'b0;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        load_d      = 1'b0;
        busy_d      = busy_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d[pick]  = 1'b1;
                    sr_d         = req_data[int'(pick)*REG_WIDTH +: REG_WIDTH];
                    g_d          = pick;
                    last_d       = pick;
                    ss_n_d       = '1;
                    ss_n_d[pick] = 1'b0;
                    sel_cnt_d    = '0;
                    state_d      = SELECT;
                end
            end
            SELECT: begin
                if (ready) begin
                    load_d  = 1'b1;
                    state_d = LOAD;
                end else if (sel_cnt_q == ST_W'(SEL_TIMEOUT - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                    rsp_id_d    = g_q;
                    ss_n_d      = '1;
                    state_d     = DONE;
                end else begin
                    sel_cnt_d = sel_cnt_q + ST_W'(1);
                end
            end
            LOAD: begin
                busy_d    = 1'b1;
                mosi_d    = sr_q[REG_WIDTH-1];
                sclk_d    = 1'b0;
                div_cnt_d = '0;
                bit_cnt_d = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (div_cnt_q == DV_W'(CLK_DIV - 1)) begin
                    div_cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d    = 1'b1;
                        sr_d      = {sr_q[REG_WIDTH-2:0], MISO};
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_cnt_q == BC_W'(REG_WIDTH)) begin
                            busy_d      = 1'b0;
                            mosi_d      = 1'b0;
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = sr_q;
                            rsp_id_d    = g_q;
                            ss_n_d      = '1;
                            state_d     = DONE;
                        end else begin
                            mosi_d = sr_q[REG_WIDTH-1];
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DV_W'(1);
                end
            end
            DONE: begin
                div_cnt_d = '0;
                state_d   = GAP;
            end
            GAP: begin
                if (div_cnt_q == DV_W'(CLK_DIV - 1)) begin
                    div_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    div_cnt_d = div_cnt_q + DV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            g_q         <= '0;
            last_q      <= ID_W'(NUM_REQ - 1);
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            sel_cnt_q   <= '0;
            gnt_q       <= '0;
            ss_n_q      <= '1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            load_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            g_q         <= g_d;
            last_q      <= last_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            sel_cnt_q   <= sel_cnt_d;
            gnt_q       <= gnt_d;
            ss_n_q      <= ss_n_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            load_q      <= load_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign ss_n      = ss_n_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign s_clk     = sclk_q;
    assign MOSI      = mosi_q;
    assign load      = load_q;
    assign busy      = busy_q;

endmodule
